// File: rtl/device_pkg.sv
// Shared types and constants for the device enable-gated counter.
package device_pkg;

    localparam int DEVICE_WIDTH = 4;

    typedef logic [DEVICE_WIDTH-1:0] count_t;

    // Largest value a w-bit count can reach; the count wraps to 0 after it.
    function automatic int unsigned terminal_count(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/device_counter.sv
// Enable-gated wrapping up-counter with async active-low reset r.
// Build option DEVICE_TC_EN adds the combinational terminal-count output TC.
module device_counter
    import device_pkg::*;
#(
    parameter int WIDTH = DEVICE_WIDTH
) (
    input  logic             clk,
    input  logic             r,
    input  logic             EC,
    output logic [WIDTH-1:0] Q
`ifdef DEVICE_TC_EN
    ,
    output logic             TC
`endif
);

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            Q <= '0;
        end else if (EC) begin
            Q <= Q + 1'b1;
        end
    end

`ifdef DEVICE_TC_EN
    localparam int unsigned      TERM_INT = terminal_count(WIDTH);
    localparam logic [WIDTH-1:0] TERMINAL = TERM_INT[WIDTH-1:0];

    // Flags that the coming edge wraps; gated by r so it reads 0 in reset.
    always_comb begin
        TC = r && EC && (Q == TERMINAL);
    end
`endif

endmodule

// File: tb/tb_device_counter.sv
// Self-checking bench for device_counter against a plain arithmetic count model.
// Works in both builds; TC checks compile only with DEVICE_TC_EN.
module tb_device_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         r;
    logic         EC;
    logic [W-1:0] Q;
`ifdef DEVICE_TC_EN
    logic         TC;
`endif

    int model;
    int n_checks;
    int n_fail;

    device_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .r   (r),
        .EC  (EC),
        .Q   (Q)
`ifdef DEVICE_TC_EN
        ,
        .TC  (TC)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_tc(input string tag);
`ifdef DEVICE_TC_EN
        check(tag, {31'd0, TC}, {31'd0, (r === 1'b1) && (EC === 1'b1) && (model == MOD - 1)});
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // One clock period: drive EC at the falling edge, check Q after the rising edge.
    task automatic step(input logic en, input string tag);
        @(negedge clk);
        EC = en;
        #1;
        check_tc({tag, "_tc"});
        @(posedge clk);
        if (r && en) model = (model + 1) % MOD;
        #1;
        check(tag, {28'd0, Q}, model);
    endtask

    // Short reset pulse in the middle of a cycle, then release with EC=1.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2 r = 1'b0;
        #1;
        model = 0;
        check({tag, "_async"}, {28'd0, Q}, 0);
        #2 EC = 1'b1;
        #1;
        check_tc({tag, "_tc_rst"});
        #1 r = 1'b1;
        @(posedge clk);
        model = 1;
        #1;
        check({tag, "_first"}, {28'd0, Q}, model);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model    = 0;
        r        = 1'b0;
        EC       = 1'b0;

        // Reset dominance with the clock running and EC toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            EC = i[0];
            #1;
            check_tc("rst_tc");
            @(posedge clk);
            #1;
            check("rst_hold", {28'd0, Q}, 0);
        end

        @(negedge clk);
        EC = 1'b0;
        r  = 1'b1;

        for (int i = 0; i < 19; i++) step(1'b0, "hold");

        for (int i = 0; i < 15; i++) step(1'b1, "count");
        check("count_15", {28'd0, Q}, 15);

        step(1'b1, "wrap");
        check("wrap_zero", {28'd0, Q}, 0);
        for (int i = 0; i < 6; i++) step(1'b1, "after_wrap");

        check("at_six", {28'd0, Q}, 6);
        for (int i = 0; i < 4; i++) step(1'b0, "pause");
        step(1'b1, "resume");
        check("resume_seven", {28'd0, Q}, 7);

        step(1'b1, "to_nine");
        step(1'b1, "to_nine");
        check("at_nine", {28'd0, Q}, 9);
        pulse_reset("midreset");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset("rnd_reset");
            end else begin
                step(1'($urandom_range(0, 3) != 0), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
